// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared state encoding and default operand width for the
//               shared shift-add multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int c_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_sa_dp.sv
`default_nettype none
// ============================================================================
// Module      : mult_sa_dp
// Description : Shift-add datapath: multiplicand, multiplier, accumulator
//               and held product registers.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sa_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_capture,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_next;

    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    // Capture takes the accumulator's next value so the product lands on
    // the same edge as the final shift-add step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_a};
                r_mplier <= i_b;
                r_acc    <= '0;
            end else if (i_step) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
            if (i_capture) begin
                r_product <= w_acc_next;
            end
        end
    end

    assign o_product = r_product;

endmodule
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : mult_sched
// Description : Round-robin scheduler sharing one shift-add multiplier
//               between two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_sched
    import mult_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [1:0]           req,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic [1:0]           gnt,
    output logic                 busy,
    output logic [1:0]           done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_owner;
    logic               r_last_owner;
    logic [1:0]         r_gnt;
    logic               w_pick;
    logic               w_accept;
    logic               w_last_step;
    logic               w_release;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    // On a tie the requester not served last wins.
    always_comb begin
        w_pick = 1'b0;
        case (req)
            2'b01:   w_pick = 1'b0;
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_last_owner;
            default: w_pick = 1'b0;
        endcase
    end

    assign w_a = w_pick ? a1 : a0;
    assign w_b = w_pick ? b1 : b0;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last_step  = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_last_step  = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_release    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_gnt        <= 2'b00;
        end else begin
            if (w_accept) begin
                r_owner <= w_pick;
                r_gnt   <= w_pick ? 2'b10 : 2'b01;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_release) begin
                r_gnt        <= 2'b00;
                r_last_owner <= r_owner;
            end
        end
    end

    mult_sa_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .i_load    (w_accept),
        .i_step    (r_state == ST_RUN),
        .i_capture (w_last_step),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_product (product)
    );

    assign gnt  = r_gnt;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE) ? r_gnt : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_sched
// Description : Scoreboard bench for mult_sched with a cycle-level
//               transaction model of arbitration and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sched;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req;
    logic [W-1:0]   a0, b0, a1, b1;
    logic [1:0]     gnt;
    logic           busy;
    logic [1:0]     done;
    logic [2*W-1:0] product;

    always #5 clk = ~clk;

    mult_sched #(.WIDTH(W)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .req      (req),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    typedef struct {
        logic           owner;
        logic [2*W-1:0] prod;
        int             done_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } job_t;

    exp_t           sb[$];
    job_t           jobs0[$];
    job_t           jobs1[$];
    logic [1:0]     done_log[$];
    int             cyc = 0;
    int             tests = 0;
    int             fails = 0;
    int             m_free = 0;
    logic           m_last = 1'b1;
    int             m_acc = -1;
    int             reset_at = -1;
    bit             rand_idle = 1'b0;
    logic [2*W-1:0] held_prod = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: expected gnt/busy/done derived from the head transaction's window.
    always @(negedge clk) begin : mon
        logic [1:0] e_gnt;
        logic [1:0] e_done;
        e_gnt  = 2'b00;
        e_done = 2'b00;
        if (sb.size() > 0 && cyc >= sb[0].done_cyc - W)
            e_gnt = sb[0].owner ? 2'b10 : 2'b01;
        if (sb.size() > 0 && cyc >= sb[0].done_cyc)
            e_done = e_gnt;
        check("gnt", gnt, e_gnt);
        check("busy", busy, e_gnt != 2'b00);
        check("done", done, e_done);
        if (done != 2'b00) done_log.push_back(done);
        if (e_done != 2'b00) begin
            held_prod = sb[0].prod;
            void'(sb.pop_front());
        end
        check("product", product, held_prod);
    end

    // One cycle of stimulus; predicts acceptance at the coming edge.
    task automatic step();
        int             e;
        logic [1:0]     r;
        logic           w;
        job_t           j;
        exp_t           x;
        logic [2*W-1:0] pa, pb;
        @(posedge clk);
        #1;
        if (cyc == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_gnt", gnt, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_product", product, 0);
            sb.delete();
            held_prod = '0;
            m_last    = 1'b1;
            m_free    = 0;
            reset_at  = -1;
            #1 rst_n = 1'b1;
        end
        e  = cyc + 1;
        r  = 2'($urandom);
        a0 = W'($urandom); b0 = W'($urandom);
        a1 = W'($urandom); b1 = W'($urandom);
        if (e >= m_free) begin
            r = {jobs1.size() > 0, jobs0.size() > 0};
            if (rand_idle && $urandom_range(0, 3) == 0) r = 2'b00;
            if (r[0]) begin a0 = jobs0[0].a; b0 = jobs0[0].b; end
            if (r[1]) begin a1 = jobs1[0].a; b1 = jobs1[0].b; end
            if (r != 2'b00) begin
                w = (r == 2'b11) ? ~m_last : r[1];
                j = w ? jobs1.pop_front() : jobs0.pop_front();
                pa = {{W{1'b0}}, j.a};
                pb = {{W{1'b0}}, j.b};
                x.owner    = w;
                x.prod     = pa * pb;
                x.done_cyc = e + W;
                sb.push_back(x);
                m_last = w;
                m_free = e + W + 2;
                m_acc  = e;
            end
        end
        req = r;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((jobs0.size() + jobs1.size() + sb.size()) > 0 && n < budget) begin
            step();
            n++;
        end
        check(name, n < budget, 1);
    endtask

    initial begin
        job_t jb;
        rst_n = 1'b0;
        req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_gnt", gnt, 0);
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_product", product, 0);
        rst_n = 1'b1;

        // Both requesters held: 0 first after reset, then 1, then 0 again
        done_log.delete();
        jobs0.push_back('{a: 4'h3, b: 4'h5});
        jobs0.push_back('{a: 4'h3, b: 4'h5});
        jobs1.push_back('{a: 4'h7, b: 4'h9});
        drain("rr_drain", 40);
        check("rr_count", done_log.size(), 3);
        if (done_log.size() >= 3) begin
            check("rr_first", done_log[0], 2'b01);
            check("rr_second", done_log[1], 2'b10);
            check("rr_third", done_log[2], 2'b01);
        end
        check("rr_prod", product, 8'h0F);

        jobs0.push_back('{a: 4'hF, b: 4'hF});
        drain("ff_drain", 20);
        check("ff_prod", product, 8'hE1);

        jobs0.push_back('{a: 4'h0, b: 4'hA});
        drain("zero_a_drain", 20);
        check("zero_a_prod", product, 8'h00);
        jobs0.push_back('{a: 4'hA, b: 4'h0});
        drain("zero_b_drain", 20);
        check("zero_b_prod", product, 8'h00);

        // Reset on the second RUN cycle aborts the job silently
        jobs0.push_back('{a: 4'hC, b: 4'h7});
        jobs1.push_back('{a: 4'h6, b: 4'h7});
        m_acc = -1;
        for (int n = 0; n < 10 && m_acc < 0; n++) step();
        check("rst_accept_seen", m_acc >= 0, 1);
        reset_at = m_acc + 1;
        for (int n = 0; n < 10 && reset_at >= 0; n++) step();
        check("rst_applied", reset_at, -1);
        jobs0.delete();
        jobs1.delete();
        repeat (W + 4) step();
        jobs0.push_back('{a: 4'h5, b: 4'h3});
        drain("post_rst_drain", 20);
        check("post_rst_prod", product, 8'h0F);

        for (int i = 0; i < 256; i++) begin
            jb.a = W'(i >> 4);
            jb.b = W'(i);
            jobs1.push_back(jb);
        end
        drain("exh_drain", 256 * (W + 2) + 50);

        rand_idle = 1'b1;
        for (int i = 0; i < 150; i++) begin
            jb.a = W'($urandom);
            jb.b = W'($urandom);
            if ($urandom_range(0, 1) == 0) jobs0.push_back(jb);
            else jobs1.push_back(jb);
        end
        drain("rand_drain", 4000);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
